// File: rtl/mario_anim_pkg.sv
// Shared types and constants for Mario sprite sequencing.
package mario_anim_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WALK1 = 3'd1,
        WALK2 = 3'd2,
        WALK3 = 3'd3,
        JUMP  = 3'd4
    } pose_t;

    localparam int unsigned SPRITE_W_C    = 21;
    localparam int unsigned SPRITE_H_C    = 21;
    localparam int unsigned SPRITE_ADDR_W = 9;
    localparam int unsigned COORD_W       = 10;

    // Walk-cycle successor: WALK1 -> WALK2 -> WALK3 -> WALK1.
    function automatic logic [2:0] next_walk(input logic [2:0] cur);
        logic [2:0] nxt;
        nxt = 3'(WALK1);
        case (cur)
            3'(WALK1): nxt = 3'(WALK2);
            3'(WALK2): nxt = 3'(WALK3);
            default:   nxt = 3'(WALK1);
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Registered draw-position to sprite-ROM address converter with optional column mirroring.
module sprite_addr_gen
    import mario_anim_pkg::*;
#(
    parameter int unsigned OBJ_W     = SPRITE_W_C,
    parameter int unsigned OBJ_H     = SPRITE_H_C,
    parameter int unsigned MIRROR_EN = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COORD_W-1:0]       obj_x,
    input  logic [COORD_W-1:0]       obj_y,
    input  logic [COORD_W-1:0]       draw_x,
    input  logic [COORD_W-1:0]       draw_y,
    input  logic                     mirror,
    output logic [SPRITE_ADDR_W-1:0] read_address,
    output logic                     obj_on
);

    logic [COORD_W:0]         dx;
    logic [COORD_W:0]         dy;
    logic                     in_x;
    logic                     in_y;
    logic                     in_c;
    logic [SPRITE_ADDR_W-1:0] col_c;
    logic [SPRITE_ADDR_W-1:0] addr_c;

    // Signed 11-bit offsets; the sign bit rejects pixels left of / above the sprite.
    assign dx   = {1'b0, draw_x} - {1'b0, obj_x};
    assign dy   = {1'b0, draw_y} - {1'b0, obj_y};
    assign in_x = !dx[COORD_W] && (dx[COORD_W-1:0] < COORD_W'(OBJ_W));
    assign in_y = !dy[COORD_W] && (dy[COORD_W-1:0] < COORD_W'(OBJ_H));
    assign in_c = in_x && in_y;

    // Column select and row-major address; only meaningful when in_c holds.
    always_comb begin
        col_c  = dx[SPRITE_ADDR_W-1:0];
        addr_c = '0;
        if ((MIRROR_EN != 0) && mirror) begin
            col_c = SPRITE_ADDR_W'(OBJ_W - 1) - dx[SPRITE_ADDR_W-1:0];
        end
        if (in_c) begin
            addr_c = dy[SPRITE_ADDR_W-1:0] * SPRITE_ADDR_W'(OBJ_W) + col_c;
        end
    end

    // One-cycle registered address and on-sprite flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_address <= '0;
            obj_on       <= 1'b0;
        end else begin
            read_address <= addr_c;
            obj_on       <= in_c;
        end
    end

endmodule

// File: rtl/mario_anim_ctrl.sv
// Mario pose/facing sequencer driven by the frame tick, plus sprite address stage.
module mario_anim_ctrl
    import mario_anim_pkg::*;
#(
    parameter int unsigned SPRITE_W        = SPRITE_W_C,
    parameter int unsigned SPRITE_H        = SPRITE_H_C,
    parameter int unsigned FRAMES_PER_STEP = 6,
    parameter int unsigned MIRROR_LEFT     = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        on_ground,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [2:0]  pose,
    output logic        facing_left,
    output logic [8:0]  read_address,
    output logic        mario_on
);

    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_WALK1 = 3'(WALK1);
    localparam logic [2:0] S_JUMP  = 3'(JUMP);

    logic             frame_clk_d;
    logic             tick_c;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_cnt_nxt;
    logic [2:0]       pose_nxt;
    logic             facing_nxt;
    logic             one_key_c;

    assign tick_c    = frame_clk & ~frame_clk_d;
    assign one_key_c = move_left ^ move_right;

    // State registers: frame_clk history, pose, step counter, facing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= 1'b0;
            pose        <= S_IDLE;
            step_cnt    <= '0;
            facing_left <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            pose        <= pose_nxt;
            step_cnt    <= step_cnt_nxt;
            facing_left <= facing_nxt;
        end
    end

    // Next pose, counter and facing; everything holds between frame ticks.
    always_comb begin
        pose_nxt     = pose;
        step_cnt_nxt = step_cnt;
        facing_nxt   = facing_left;
        if (tick_c) begin
            if (!on_ground) begin
                pose_nxt     = S_JUMP;
                step_cnt_nxt = '0;
            end else if (one_key_c) begin
                if ((pose == S_IDLE) || (pose == S_JUMP)) begin
                    pose_nxt     = S_WALK1;
                    step_cnt_nxt = '0;
                end else if (step_cnt == CNT_LAST) begin
                    pose_nxt     = next_walk(pose);
                    step_cnt_nxt = '0;
                end else begin
                    step_cnt_nxt = step_cnt + CNT_W'(1);
                end
            end else begin
                pose_nxt     = S_IDLE;
                step_cnt_nxt = '0;
            end
            if (move_right && !move_left) begin
                facing_nxt = 1'b0;
            end else if (move_left && !move_right) begin
                facing_nxt = 1'b1;
            end
        end
    end

    // Pixel address stage sees the facing value registered before this edge.
    sprite_addr_gen #(
        .OBJ_W     (SPRITE_W),
        .OBJ_H     (SPRITE_H),
        .MIRROR_EN (MIRROR_LEFT)
    ) u_addr (
        .clk          (Clk),
        .rst          (Reset),
        .obj_x        (mario_x),
        .obj_y        (mario_y),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .mirror       (facing_left),
        .read_address (read_address),
        .obj_on       (mario_on)
    );

endmodule

// File: tb/tb_mario_anim_ctrl.sv
// Scoreboard bench for mario_anim_ctrl: plain and mirrored instances share stimulus.
module tb_mario_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       move_left;
    logic       move_right;
    logic       on_ground;
    logic [9:0] mario_x;
    logic [9:0] mario_y;
    logic [9:0] draw_x;
    logic [9:0] draw_y;

    logic [2:0] pose;
    logic       facing_left;
    logic [8:0] read_address;
    logic       mario_on;
    logic [2:0] pose_m;
    logic       facing_m;
    logic [8:0] addr_m;
    logic       on_m;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    // Mask bits: 0 pose, 1 facing, 2 on, 3 addr, 4 mirrored addr.
    typedef struct {
        string      name;
        int         due;
        logic [4:0] mask;
        logic [2:0] pose;
        logic       face;
        logic       on;
        logic [8:0] addr;
        logic [8:0] addr_m;
    } exp_t;

    exp_t sb[$];

    mario_anim_ctrl #(.FRAMES_PER_STEP(6), .MIRROR_LEFT(0)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .move_left(move_left), .move_right(move_right), .on_ground(on_ground),
        .mario_x(mario_x), .mario_y(mario_y), .draw_x(draw_x), .draw_y(draw_y),
        .pose(pose), .facing_left(facing_left),
        .read_address(read_address), .mario_on(mario_on)
    );

    mario_anim_ctrl #(.FRAMES_PER_STEP(6), .MIRROR_LEFT(1)) dut_m (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .move_left(move_left), .move_right(move_right), .on_ground(on_ground),
        .mario_x(mario_x), .mario_y(mario_y), .draw_x(draw_x), .draw_y(draw_y),
        .pose(pose_m), .facing_left(facing_m),
        .read_address(addr_m), .mario_on(on_m)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input string field, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s.%s got=%0d expected=%0d (cycle %0d)", name, field, act, expv, cyc);
        end
    endtask

    // Monitor: compares every scoreboard entry at the falling edge of its due cycle.
    always @(negedge Clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk(e.name, "late", cyc, e.due);
            end else begin
                if (e.mask[0]) chk(e.name, "pose",   int'(pose),         int'(e.pose));
                if (e.mask[1]) chk(e.name, "facing", int'(facing_left),  int'(e.face));
                if (e.mask[2]) chk(e.name, "on",     int'(mario_on),     int'(e.on));
                if (e.mask[3]) chk(e.name, "addr",   int'(read_address), int'(e.addr));
                if (e.mask[4]) chk(e.name, "addr_m", int'(addr_m),       int'(e.addr_m));
            end
        end
    end

    function automatic void push(input string name, input int due, input logic [4:0] mask,
                                 input logic [2:0] p, input logic f, input logic on,
                                 input logic [8:0] a, input logic [8:0] am);
        exp_t e;
        e.name = name; e.due = due; e.mask = mask; e.pose = p; e.face = f;
        e.on = on; e.addr = a; e.addr_m = am;
        sb.push_back(e);
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One frame tick: rising frame_clk, result visible after the next edge.
    task automatic tick(input string name, input logic [2:0] p, input logic f);
        frame_clk = 1'b1;
        push(name, cyc + 1, 5'b00011, p, f, 1'b0, 9'd0, 9'd0);
        step();
        frame_clk = 1'b0;
        step();
    endtask

    // One pixel: registered address/on-flag expected one cycle later.
    task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                       input logic on, input logic [8:0] a, input logic [8:0] am);
        draw_x = x;
        draw_y = y;
        push(name, cyc + 1, 5'b11100, 3'd0, 1'b0, on, a, am);
        step();
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; move_left = 1'b0; move_right = 1'b0;
        on_ground = 1'b1; mario_x = 10'd100; mario_y = 10'd50; draw_x = 10'd0; draw_y = 10'd0;
        step(); step(); step();
        Reset = 1'b0;
        push("reset", cyc, 5'b11111, 3'd0, 1'b0, 1'b0, 9'd0, 9'd0);
        step();

        for (int i = 0; i < 3; i++) tick("idle_tick", 3'd0, 1'b0);
        push("idle_after", cyc, 5'b11111, 3'd0, 1'b0, 1'b0, 9'd0, 9'd0);
        step();

        // Walk right: WALK1 at tick 1, WALK2 at 7, WALK3 at 13, WALK1 at 19.
        move_right = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            tick($sformatf("walk_t%0d", i), (i == 1) ? 3'd1 : 3'(((i - 1) / 6) % 3 + 1), 1'b0);
        end

        // Jump while pressing left, hold airborne, land with no keys.
        on_ground = 1'b0; move_right = 1'b0; move_left = 1'b1;
        tick("jump", 3'd4, 1'b1);
        tick("jump_hold", 3'd4, 1'b1);
        on_ground = 1'b1; move_left = 1'b0;
        tick("land_idle", 3'd0, 1'b1);

        // frame_clk held high for 100 cycles must tick once only.
        move_right = 1'b1;
        frame_clk = 1'b1;
        push("hold_first", cyc + 1, 5'b00011, 3'd1, 1'b0, 1'b0, 9'd0, 9'd0);
        for (int i = 0; i < 100; i++) step();
        push("hold_level", cyc, 5'b00011, 3'd1, 1'b0, 1'b0, 9'd0, 9'd0);
        frame_clk = 1'b0;
        step();
        tick("after_hold", 3'd1, 1'b0);

        // Turn left while walking, then both keys -> IDLE, facing held.
        move_right = 1'b0; move_left = 1'b1;
        tick("turn_left", 3'd1, 1'b1);
        move_right = 1'b1;
        tick("both_keys", 3'd0, 1'b1);

        // Walk left into WALK2, then reset coinciding with a tick.
        move_right = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick($sformatf("lwalk_t%0d", i), (i == 7) ? 3'd2 : 3'd1, 1'b1);
        end
        frame_clk = 1'b1; Reset = 1'b1;
        push("reset_mid", cyc + 1, 5'b00011, 3'd0, 1'b0, 1'b0, 9'd0, 9'd0);
        step();
        frame_clk = 1'b0; Reset = 1'b0; move_left = 1'b0;
        step();

        // Address stage, mario=(100,50), facing right, back-to-back pixels.
        pix("px_origin", 10'd100, 10'd50, 1'b1, 9'd0, 9'd0);
        pix("px_corner", 10'd120, 10'd70, 1'b1, 9'd440, 9'd440);
        pix("px_right_out", 10'd121, 10'd50, 1'b0, 9'd0, 9'd0);
        pix("px_left_out", 10'd99, 10'd50, 1'b0, 9'd0, 9'd0);
        pix("px_above", 10'd100, 10'd49, 1'b0, 9'd0, 9'd0);
        pix("px_bottom", 10'd100, 10'd70, 1'b1, 9'd420, 9'd420);
        pix("px_top_right", 10'd120, 10'd50, 1'b1, 9'd20, 9'd20);

        // No wrap-around at origin.
        mario_x = 10'd0; mario_y = 10'd0;
        pix("px_wrap_x", 10'd1023, 10'd0, 1'b0, 9'd0, 9'd0);
        pix("px_wrap_y", 10'd0, 10'd1023, 1'b0, 9'd0, 9'd0);
        pix("px_r_row1", 10'd0, 10'd1, 1'b1, 9'd21, 9'd21);

        // Face left: mirrored instance flips the column.
        move_left = 1'b1;
        tick("face_left", 3'd1, 1'b1);
        move_left = 1'b0;
        pix("px_l_row1", 10'd0, 10'd1, 1'b1, 9'd21, 9'd41);
        pix("px_l_col20", 10'd20, 10'd0, 1'b1, 9'd20, 9'd0);
        pix("px_l_col0", 10'd0, 10'd0, 1'b1, 9'd0, 9'd20);

        // Tick and pixel in the same cycle: address uses the pre-tick facing.
        move_right = 1'b1;
        frame_clk = 1'b1;
        draw_x = 10'd0; draw_y = 10'd1;
        push("same_cycle", cyc + 1, 5'b11111, 3'd1, 1'b0, 1'b1, 9'd21, 9'd41);
        step();
        frame_clk = 1'b0;
        push("next_cycle", cyc + 1, 5'b11100, 3'd0, 1'b0, 1'b1, 9'd21, 9'd21);
        step();
        move_right = 1'b0;

        // Drain scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        if (sb.size() > 0) chk("drain", "pending", sb.size(), 0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
